// File: rtl/core_types_pkg.sv
// Shared core widths and the LBPT index type.
package core_types_pkg;

    localparam int unsigned LH_LENGTH        = 8;
    localparam int unsigned ASID_WIDTH       = 9;
    localparam int unsigned LBPT_INDEX_WIDTH = 8;

    // One LBPT table index; the table depth is 2**LBPT_INDEX_WIDTH.
    typedef logic [LBPT_INDEX_WIDTH-1:0] lbpt_index_t;

endpackage : core_types_pkg

// File: rtl/lbpt_index_hash_xor_fold.sv
// xor_fold: combinational XOR fold of an IN_WIDTH vector down to OUT_WIDTH bits.
//   in_i  [IN_WIDTH-1:0]   vector to fold; chunked from the LSB upward
//   out_o [OUT_WIDTH-1:0]  XOR of all OUT_WIDTH chunks (last chunk zero-extended)
module xor_fold #(
    parameter int unsigned IN_WIDTH  = 30,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic [IN_WIDTH-1:0]  in_i,
    output logic [OUT_WIDTH-1:0] out_o
);

    localparam int unsigned NCHUNK = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int unsigned PAD_W  = NCHUNK * OUT_WIDTH;

    // Zero-extending to a whole number of chunks pads the final partial chunk.
    logic [PAD_W-1:0] padded;
    assign padded = PAD_W'(in_i);

    // Running XOR chain: acc[g+1] folds in chunk g.
    logic [OUT_WIDTH-1:0] acc [NCHUNK+1];
    assign acc[0] = '0;

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign acc[g+1] = acc[g] ^ padded[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign out_o = acc[NCHUNK];

endmodule : xor_fold

// File: rtl/lbpt_index_hash.sv
// lbpt_index_hash: registered LBPT index = Fold(PC[31:2]) ^ Fold(LH) ^ Fold(ASID).
//   CLK    clock, rising edge
//   RST    synchronous active-high reset; clears index
//   PC     load PC (bits 1:0 ignored)
//   LH     load history
//   ASID   address-space ID
//   index  registered table index, one cycle after inputs are sampled
module lbpt_index_hash
    import core_types_pkg::*;
#(
    parameter int unsigned LH_W    = LH_LENGTH,
    parameter int unsigned ASID_W  = ASID_WIDTH,
    parameter int unsigned INDEX_W = LBPT_INDEX_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        PC,
    input  logic [LH_W-1:0]    LH,
    input  logic [ASID_W-1:0]  ASID,
    output logic [INDEX_W-1:0] index
);

    localparam int unsigned PC_FOLD_W = 30;

    logic [INDEX_W-1:0] pc_fold;
    logic [INDEX_W-1:0] lh_fold;
    logic [INDEX_W-1:0] asid_fold;
    logic [INDEX_W-1:0] index_d;
    logic [INDEX_W-1:0] index_q;

    // Instruction alignment bits carry no information for the hash.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^PC[1:0];

    xor_fold #(
        .IN_WIDTH  (PC_FOLD_W),
        .OUT_WIDTH (INDEX_W)
    ) u_fold_pc (
        .in_i  (PC[31:2]),
        .out_o (pc_fold)
    );

    xor_fold #(
        .IN_WIDTH  (LH_W),
        .OUT_WIDTH (INDEX_W)
    ) u_fold_lh (
        .in_i  (LH),
        .out_o (lh_fold)
    );

    xor_fold #(
        .IN_WIDTH  (ASID_W),
        .OUT_WIDTH (INDEX_W)
    ) u_fold_asid (
        .in_i  (ASID),
        .out_o (asid_fold)
    );

    // Combine the three folds.
    always_comb begin
        index_d = pc_fold ^ lh_fold ^ asid_fold;
    end

    // Index register: captures every cycle, synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            index_q <= '0;
        end else begin
            index_q <= index_d;
        end
    end

    assign index = index_q;

endmodule : lbpt_index_hash

// File: tb/tb_lbpt_index_hash.sv
// Self-checking bench for lbpt_index_hash: directed vectors plus random traffic,
// expected indices queued at each sampling edge and checked by a monitor.
module tb_lbpt_index_hash;

    logic        CLK;
    logic        RST;
    logic [31:0] PC;
    logic [7:0]  LH;
    logic [8:0]  ASID;
    logic [7:0]  index;

    lbpt_index_hash dut (
        .CLK   (CLK),
        .RST   (RST),
        .PC    (PC),
        .LH    (LH),
        .ASID  (ASID),
        .index (index)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] exp_q  [$];
    string      name_q [$];
    int         n_compared   = 0;
    int         n_mismatched = 0;
    bit         stim_done    = 1'b0;

    // Reference: bit i of the index is the parity of every input bit whose
    // position within its field (PC counted from bit 2) is congruent to i mod 8.
    function automatic logic [7:0] ref_hash(input logic rst, input logic [31:0] pc,
                                            input logic [7:0] lh, input logic [8:0] asid);
        logic [7:0] r;
        r = 8'h00;
        if (rst) return r;
        for (int k = 0; k < 30; k++) r[k % 8] = r[k % 8] ^ pc[k + 2];
        for (int k = 0; k < 8; k++)  r[k % 8] = r[k % 8] ^ lh[k];
        for (int k = 0; k < 9; k++)  r[k % 8] = r[k % 8] ^ asid[k];
        return r;
    endfunction

    // Drive one input vector before the next edge, then queue its expected index.
    task automatic apply(input logic rst, input logic [31:0] pc, input logic [7:0] lh,
                         input logic [8:0] asid, input logic [7:0] exp_idx, input string nm);
        @(negedge CLK);
        RST  = rst;
        PC   = pc;
        LH   = lh;
        ASID = asid;
        @(posedge CLK);
        exp_q.push_back(exp_idx);
        name_q.push_back(nm);
    endtask

    task automatic apply_rand(input logic rst, input string nm);
        logic [31:0] pc;
        logic [7:0]  lh;
        logic [8:0]  asid;
        pc   = $urandom;
        lh   = 8'($urandom);
        asid = 9'($urandom);
        apply(rst, pc, lh, asid, ref_hash(rst, pc, lh, asid), nm);
    endtask

    // Monitor: index is registered, so check shortly after each edge.
    initial begin
        logic [7:0] e;
        string      nm;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_compared++;
                if (index !== e) begin
                    n_mismatched++;
                    $display("FAIL %s: index=0x%02h expected=0x%02h at %0t", nm, index, e, $time);
                end
            end
        end
    end

    initial begin
        RST  = 1'b1;
        PC   = 32'hFFFF_FFFF;
        LH   = 8'hFF;
        ASID = 9'h1FF;

        // Reset with all-ones inputs, held for two cycles.
        apply(1'b1, 32'hFFFF_FFFF, 8'hFF, 9'h1FF, 8'h00, "reset0");
        apply(1'b1, 32'hFFFF_FFFF, 8'hFF, 9'h1FF, 8'h00, "reset1");

        // Zero and alignment bits.
        apply(1'b0, 32'h0000_0000, 8'h00, 9'h000, 8'h00, "zero");
        apply(1'b0, 32'h0000_0003, 8'h00, 9'h000, 8'h00, "pc_lsbs_ignored");

        // PC folding.
        apply(1'b0, 32'h0000_0004, 8'h00, 9'h000, 8'h01, "pc_4");
        apply(1'b0, 32'h0000_0400, 8'h00, 9'h000, 8'h01, "pc_400_alias");
        apply(1'b0, 32'h0000_0404, 8'h00, 9'h000, 8'h00, "pc_404_cancel");
        apply(1'b0, 32'hFFFF_FFFF, 8'h00, 9'h000, 8'hC0, "pc_all_ones");

        // LH and ASID folding, including the lone ASID[8] chunk.
        apply(1'b0, 32'h0000_0000, 8'hA5, 9'h100, 8'hA4, "lh_asid_msb");
        apply(1'b0, 32'h0000_0000, 8'hA5, 9'h0FF, 8'h5A, "lh_asid_low");

        // Back-to-back changing inputs, then a one-cycle reset mid-stream.
        apply(1'b0, 32'h1234_5678, 8'h3C, 9'h0AA, ref_hash(1'b0, 32'h1234_5678, 8'h3C, 9'h0AA), "stream0");
        apply(1'b0, 32'hDEAD_BEEF, 8'h81, 9'h155, ref_hash(1'b0, 32'hDEAD_BEEF, 8'h81, 9'h155), "stream1");
        apply(1'b1, 32'hCAFE_F00D, 8'h7E, 9'h1C3, 8'h00, "mid_reset");
        apply(1'b0, 32'hCAFE_F00D, 8'h7E, 9'h1C3, ref_hash(1'b0, 32'hCAFE_F00D, 8'h7E, 9'h1C3), "resume");
        apply(1'b0, 32'hCAFE_F00D, 8'h7E, 9'h1C3, ref_hash(1'b0, 32'hCAFE_F00D, 8'h7E, 9'h1C3), "repeat_same");

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            apply_rand(($urandom_range(0, 15) == 0), "random");
        end

        stim_done = 1'b1;
    end

    // Finish once stimulus is done and the queue drains, bounded by a cycle budget.
    initial begin
        int cycles;
        cycles = 0;
        while (!(stim_done && exp_q.size() == 0) && cycles < 2000) begin
            @(posedge CLK);
            cycles++;
        end
        repeat (2) @(posedge CLK);
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_lbpt_index_hash
